// File: rtl/mod3_sequence_monitor.sv
// Monitor for the two-bit modulo-3 counter: registered one-hot phase, BCD count of
// completed 0->1->2->0 cycles, and sticky/saturating flags for illegal states or steps.
module mod3_sequence_monitor #(
    parameter bit CHECK_SEQUENCE = 1'b1
) (
    input  logic       clockpulse,
    input  logic       clear_,
    input  logic [1:0] signal_q,
    input  logic       error_ack,
    output logic [2:0] phase,
    output logic       wrap,
    output logic [7:0] cycle_bcd,
    output logic       overflow,
    output logic       seq_error,
    output logic [3:0] error_count
);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t     state, state_nxt;
    logic [1:0] prev_p0;
    logic       legal_step;
    logic       err_event;
    logic       wrap_event;
    logic [8:0] bcd_next;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Returns {carry_out_of_99, next_tens, next_units}; each digit stays within 0..9.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v);
        logic [3:0] units;
        logic [3:0] tens;
        logic       carry;
        units = v[3:0];
        tens  = v[7:4];
        carry = 1'b0;
        if (units >= 4'd9) begin
            units = 4'd0;
            if (tens >= 4'd9) begin
                tens  = 4'd0;
                carry = 1'b1;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {carry, tens, units};
    endfunction

    function automatic logic [2:0] decode_phase(input logic [1:0] v);
        logic [2:0] p;
        case (v)
            2'b00:   p = 3'b001;
            2'b01:   p = 3'b010;
            2'b10:   p = 3'b100;
            default: p = 3'b000;
        endcase
        return p;
    endfunction

    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) state <= SYNC;
        else         state <= state_nxt;
    end

    // 11->00 is the counter's own recovery step, so it is accepted but never wraps.
    always_comb begin
        state_nxt  = state;
        legal_step = 1'b0;
        err_event  = 1'b0;
        wrap_event = 1'b0;
        if (state == SYNC) begin
            state_nxt = TRACK;
        end else begin
            legal_step = (prev_p0 == 2'b00 && signal_q == 2'b01) ||
                         (prev_p0 == 2'b01 && signal_q == 2'b10) ||
                         (prev_p0 == 2'b10 && signal_q == 2'b00) ||
                         (prev_p0 == 2'b11 && signal_q == 2'b00);
            if (signal_q == 2'b11)
                err_event = 1'b1;
            else if (CHECK_SEQUENCE && !legal_step)
                err_event = 1'b1;
            wrap_event = (prev_p0 == 2'b10) && (signal_q == 2'b00);
        end
    end

    assign bcd_next = bcd_inc(cycle_bcd);

    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            prev_p0     <= 2'b00;
            phase       <= 3'b000;
            wrap        <= 1'b0;
            cycle_bcd   <= 8'h00;
            overflow    <= 1'b0;
            seq_error   <= 1'b0;
            error_count <= 4'h0;
        end else begin
            prev_p0 <= signal_q;
            phase   <= decode_phase(signal_q);
            wrap    <= wrap_event;
            if (wrap_event) begin
                cycle_bcd <= bcd_next[7:0];
                if (bcd_next[8]) overflow <= 1'b1;
            end
            // An error on the acknowledge edge wins and restarts the count at one.
            if (err_event) begin
                seq_error   <= 1'b1;
                error_count <= error_ack ? 4'h1 : sat_inc(error_count);
            end else if (error_ack) begin
                seq_error   <= 1'b0;
                error_count <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_mod3_sequence_monitor.sv
// Directed bench for mod3_sequence_monitor; a second instance runs with step checking off.
module tb_mod3_sequence_monitor;

    logic       clockpulse;
    logic       clear_;
    logic [1:0] signal_q;
    logic       error_ack;

    logic [2:0] phase,       phase_nc;
    logic       wrap,        wrap_nc;
    logic [7:0] cycle_bcd,   cycle_bcd_nc;
    logic       overflow,    overflow_nc;
    logic       seq_error,   seq_error_nc;
    logic [3:0] error_count, error_count_nc;

    int n_tests = 0;
    int n_fail  = 0;
    int wrap_cnt;

    mod3_sequence_monitor #(.CHECK_SEQUENCE(1'b1)) u_dut (
        .clockpulse (clockpulse),
        .clear_     (clear_),
        .signal_q   (signal_q),
        .error_ack  (error_ack),
        .phase      (phase),
        .wrap       (wrap),
        .cycle_bcd  (cycle_bcd),
        .overflow   (overflow),
        .seq_error  (seq_error),
        .error_count(error_count)
    );

    mod3_sequence_monitor #(.CHECK_SEQUENCE(1'b0)) u_dut_nc (
        .clockpulse (clockpulse),
        .clear_     (clear_),
        .signal_q   (signal_q),
        .error_ack  (error_ack),
        .phase      (phase_nc),
        .wrap       (wrap_nc),
        .cycle_bcd  (cycle_bcd_nc),
        .overflow   (overflow_nc),
        .seq_error  (seq_error_nc),
        .error_count(error_count_nc)
    );

    initial clockpulse = 1'b0;
    always #5 clockpulse = ~clockpulse;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge like the real counter; outputs read 1 after the rising edge.
    task automatic drive(input logic [1:0] v, input logic ack);
        @(negedge clockpulse);
        signal_q  = v;
        error_ack = ack;
        @(posedge clockpulse);
        #1;
    endtask

    task automatic release_with(input logic [1:0] v);
        @(negedge clockpulse);
        clear_    = 1'b1;
        signal_q  = v;
        error_ack = 1'b0;
        @(posedge clockpulse);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"},   {29'd0, phase},       32'h0);
        check_eq({tag, "_wrap"},    {31'd0, wrap},        32'h0);
        check_eq({tag, "_bcd"},     {24'd0, cycle_bcd},   32'h0);
        check_eq({tag, "_ovf"},     {31'd0, overflow},    32'h0);
        check_eq({tag, "_err"},     {31'd0, seq_error},   32'h0);
        check_eq({tag, "_errcnt"},  {28'd0, error_count}, 32'h0);
    endtask

    logic [1:0] seq_in  [10] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [2:0] seq_ph  [10] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    logic       seq_wr  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        clear_    = 1'b0;
        signal_q  = 2'b00;
        error_ack = 1'b0;
        #12;
        check_all_zero("reset");

        // Three free-running cycles; first sample is the SYNC edge.
        wrap_cnt = 0;
        release_with(seq_in[0]);
        check_eq("seq_phase0", {29'd0, phase}, {29'd0, seq_ph[0]});
        check_eq("seq_wrap0",  {31'd0, wrap},  {31'd0, seq_wr[0]});
        for (int i = 1; i < 10; i++) begin
            drive(seq_in[i], 1'b0);
            check_eq($sformatf("seq_phase%0d", i), {29'd0, phase}, {29'd0, seq_ph[i]});
            check_eq($sformatf("seq_wrap%0d", i),  {31'd0, wrap},  {31'd0, seq_wr[i]});
            wrap_cnt += int'(wrap);
        end
        check_eq("seq_wrapcnt", wrap_cnt, 3);
        check_eq("seq_bcd", {24'd0, cycle_bcd}, 32'h03);
        check_eq("seq_err", {31'd0, seq_error}, 32'h0);

        // 100 complete cycles through 09->10 and 99->00.
        clear_ = 1'b0;
        #3;
        release_with(2'b00);
        wrap_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            drive(2'b01, 1'b0);
            wrap_cnt += int'(wrap);
            drive(2'b10, 1'b0);
            wrap_cnt += int'(wrap);
            drive(2'b00, 1'b0);
            wrap_cnt += int'(wrap);
            if (i == 8)  check_eq("bcd_09", {24'd0, cycle_bcd}, 32'h09);
            if (i == 9)  check_eq("bcd_10", {24'd0, cycle_bcd}, 32'h10);
            if (i == 98) begin
                check_eq("bcd_99", {24'd0, cycle_bcd}, 32'h99);
                check_eq("ovf_99", {31'd0, overflow},  32'h0);
            end
        end
        check_eq("bcd_00",    {24'd0, cycle_bcd}, 32'h00);
        check_eq("ovf_set",   {31'd0, overflow},  32'h1);
        check_eq("wrap_100",  wrap_cnt, 100);
        check_eq("long_err",  {31'd0, seq_error}, 32'h0);

        // Illegal state 11, then recovery 00.
        clear_ = 1'b0;
        #3;
        release_with(2'b00);
        drive(2'b01, 1'b0);
        drive(2'b10, 1'b0);
        drive(2'b11, 1'b0);
        check_eq("ill_phase",   {29'd0, phase},       32'h0);
        check_eq("ill_err",     {31'd0, seq_error},   32'h1);
        check_eq("ill_cnt",     {28'd0, error_count}, 32'h1);
        check_eq("ill_cnt_nc",  {28'd0, error_count_nc}, 32'h1);
        drive(2'b00, 1'b0);
        check_eq("rec_wrap",    {31'd0, wrap},        32'h0);
        check_eq("rec_cnt",     {28'd0, error_count}, 32'h1);
        check_eq("rec_phase",   {29'd0, phase},       32'h1);
        check_eq("rec_bcd",     {24'd0, cycle_bcd},   32'h0);

        // Acknowledge clears the flags on a clean edge.
        drive(2'b01, 1'b1);
        check_eq("ack_err",     {31'd0, seq_error},   32'h0);
        check_eq("ack_cnt",     {28'd0, error_count}, 32'h0);
        check_eq("ack_cnt_nc",  {28'd0, error_count_nc}, 32'h0);

        // Hold 01,01 then reverse 10->01.
        drive(2'b01, 1'b0);
        check_eq("hold_cnt",    {28'd0, error_count}, 32'h1);
        drive(2'b10, 1'b0);
        drive(2'b01, 1'b0);
        check_eq("rev_cnt",     {28'd0, error_count}, 32'h2);
        check_eq("rev_err",     {31'd0, seq_error},   32'h1);
        check_eq("rev_cnt_nc",  {28'd0, error_count_nc}, 32'h0);
        check_eq("rev_err_nc",  {31'd0, seq_error_nc},   32'h0);

        // Acknowledge on the same edge as an illegal 11.
        drive(2'b11, 1'b1);
        check_eq("ackerr_err",  {31'd0, seq_error},   32'h1);
        check_eq("ackerr_cnt",  {28'd0, error_count}, 32'h1);
        check_eq("ackerr_cnt_nc", {28'd0, error_count_nc}, 32'h1);
        drive(2'b00, 1'b0);

        // Build up 42 cycles, then clear asynchronously mid-cycle.
        clear_ = 1'b0;
        #3;
        release_with(2'b00);
        for (int i = 0; i < 42; i++) begin
            drive(2'b01, 1'b0);
            drive(2'b10, 1'b0);
            drive(2'b00, 1'b0);
        end
        check_eq("pre_clr_bcd", {24'd0, cycle_bcd}, 32'h42);
        drive(2'b01, 1'b0);
        #2;
        clear_ = 1'b0;
        #1;
        check_all_zero("midclr");
        release_with(2'b10);
        check_eq("post_phase",  {29'd0, phase},     32'h4);
        check_eq("post_err",    {31'd0, seq_error}, 32'h0);
        check_eq("post_wrap",   {31'd0, wrap},      32'h0);
        drive(2'b00, 1'b0);
        check_eq("post_wrap2",  {31'd0, wrap},      32'h1);
        check_eq("post_bcd",    {24'd0, cycle_bcd}, 32'h01);
        check_eq("post_err2",   {31'd0, seq_error}, 32'h0);
        drive(2'b01, 1'b0);
        check_eq("post_wrap3",  {31'd0, wrap},      32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
